// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared definitions for the XNOR pattern correlator.
//   MAX_WIN_LEN  - largest supported window/pattern length.
//   score_width  - bit width needed to hold a count of 0..win_len.
//   fill_t       - fill-counter type, wide enough for any legal WIN_LEN.
package xcorr_pkg;

  localparam int MAX_WIN_LEN = 64;

  function automatic int score_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

  typedef logic [$clog2(MAX_WIN_LEN + 1)-1:0] fill_t;

endpackage

// File: rtl/xnor_popcount.sv
// xnor_popcount: combinational agreement counter.
// Ports:
//   window  [WIN_LEN-1:0]  current sample window
//   pattern [WIN_LEN-1:0]  reference pattern
//   count   [SCORE_W-1:0]  number of bit positions where window == pattern
module xnor_popcount
  import xcorr_pkg::*;
#(
  parameter int  WIN_LEN = 16,
  localparam int SCORE_W = score_width(WIN_LEN)
) (
  input  logic [WIN_LEN-1:0] window,
  input  logic [WIN_LEN-1:0] pattern,
  output logic [SCORE_W-1:0] count
);

  logic [WIN_LEN-1:0] agree;

  // One XNOR per bit position: 1 where the window agrees with the pattern.
  for (genvar gi = 0; gi < WIN_LEN; gi++) begin : g_xnor
    assign agree[gi] = ~(window[gi] ^ pattern[gi]);
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < WIN_LEN; i++) begin
      count = count + SCORE_W'(agree[i]);
    end
  end

endmodule

// File: rtl/xnor_correlator.sv
// xnor_correlator: bit-serial sync-word / preamble correlator.
// Serial bits shift into a WIN_LEN-bit window (newest at LSB) and are XNORed
// against a loadable reference pattern (MSB = oldest bit). The number of
// agreeing bits is registered as the score; hit flags score >= thresh.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     accept in_bit on this edge
//   in_bit       serial data bit
//   pat_load     load pat_value as the new pattern and restart the fill count
//   pat_value    reference pattern
//   thresh       hit threshold, sampled in stage 2
//   window_full  WIN_LEN bits accepted since last reset/pat_load
//   score        registered agreement count
//   score_valid  one-cycle pulse per accepted bit once the window is full
//   hit          score_valid && score >= thresh
//   hit_count    saturating count of hits (only with XCORR_HIT_COUNT_EN)
//
// Optional feature macro: XCORR_HIT_COUNT_EN adds the hit_count port/counter.
//
// Pipeline: stage 1 shifts the window on an accepted bit; stage 2, one edge
// later, scores that window. A bit sampled at edge N yields score/hit at N+1.
module xnor_correlator
  import xcorr_pkg::*;
#(
  parameter int  WIN_LEN   = 16,
  parameter int  HIT_CNT_W = 16,
  localparam int SCORE_W   = score_width(WIN_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 pat_load,
  input  logic [WIN_LEN-1:0]   pat_value,
  input  logic [SCORE_W-1:0]   thresh,
  output logic                 window_full,
  output logic [SCORE_W-1:0]   score,
  output logic                 score_valid,
  output logic                 hit
`ifdef XCORR_HIT_COUNT_EN
  ,
  output logic [HIT_CNT_W-1:0] hit_count
`endif
);

  localparam fill_t FILL_MAX = fill_t'(WIN_LEN);

  // Elaboration-time guard on the legal parameter range.
  if (WIN_LEN < 2 || WIN_LEN > MAX_WIN_LEN || HIT_CNT_W < 1) begin : g_bad_param
    $error("xnor_correlator: WIN_LEN must be 2..64 and HIT_CNT_W >= 1");
  end

  // Stage 1 state
  logic [WIN_LEN-1:0] window_q, window_d;
  logic [WIN_LEN-1:0] pattern_q, pattern_d;
  fill_t              fill_q, fill_d;
  fill_t              fill_base;
  logic               window_full_q, window_full_d;
  logic               acc_q, acc_d;

  // Stage 2 state
  logic [SCORE_W-1:0] score_q, score_d;
  logic               score_valid_q, score_valid_d;
  logic               hit_q, hit_d;
  logic [SCORE_W-1:0] pop_count;

  xnor_popcount #(
    .WIN_LEN (WIN_LEN)
  ) u_popcount (
    .window  (window_q),
    .pattern (pattern_q),
    .count   (pop_count)
  );

  // Stage 1: window shift, pattern load and saturating fill count.
  always_comb begin
    window_d  = window_q;
    pattern_d = pattern_q;
    acc_d     = in_valid;
    if (in_valid) begin
      window_d = {window_q[WIN_LEN-2:0], in_bit};
    end
    if (pat_load) begin
      pattern_d = pat_value;
    end
    // A same-edge load restarts the count before the new bit is counted,
    // so that bit becomes the first of the new window.
    fill_base = pat_load ? '0 : fill_q;
    fill_d    = fill_base;
    if (in_valid && (fill_base != FILL_MAX)) begin
      fill_d = fill_base + fill_t'(1);
    end
    window_full_d = (fill_d == FILL_MAX);
  end

  // Stage 2: score the window produced by last edge's accept. window_full_q
  // here is the fullness right after that accept. A pattern load discards
  // the in-flight result (score holds, no valid pulse).
  always_comb begin
    score_d       = score_q;
    score_valid_d = acc_q && window_full_q && !pat_load;
    if (acc_q && !pat_load) begin
      score_d = pop_count;
    end
    hit_d = score_valid_d && (pop_count >= thresh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window_q      <= '0;
      pattern_q     <= '0;
      fill_q        <= '0;
      window_full_q <= 1'b0;
      acc_q         <= 1'b0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      window_q      <= window_d;
      pattern_q     <= pattern_d;
      fill_q        <= fill_d;
      window_full_q <= window_full_d;
      acc_q         <= acc_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      hit_q         <= hit_d;
    end
  end

  assign window_full = window_full_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign hit         = hit_q;

`ifdef XCORR_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] hit_count_q, hit_count_d;

  // Counts in the same edge the hit is registered; saturates at all-ones.
  always_comb begin
    hit_count_d = hit_count_q;
    if (pat_load) begin
      hit_count_d = '0;
    end else if (hit_d && (hit_count_q != {HIT_CNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + HIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_xnor_correlator.sv
// tb_xnor_correlator: self-checking bench for xnor_correlator (WIN_LEN=8).
// A table of hand-computed vectors covers the directed cases, hand-written
// sequences cover threshold corners and the hit counter, and a random phase
// is checked every cycle against a bit-history reference model.
module tb_xnor_correlator;

  localparam int WL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       pat_load;
  logic [7:0] pat_value;
  logic [3:0] thresh;
  logic       window_full;
  logic [3:0] score;
  logic       score_valid;
  logic       hit;
`ifdef XCORR_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  xnor_correlator #(
    .WIN_LEN   (WL),
    .HIT_CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .pat_load    (pat_load),
    .pat_value   (pat_value),
    .thresh      (thresh),
    .window_full (window_full),
    .score       (score),
    .score_valid (score_valid),
    .hit         (hit)
`ifdef XCORR_HIT_COUNT_EN
    ,
    .hit_count   (hit_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the last WL bits accepted since reset (window content, including
  // bits older than the last pattern load), the count of bits since the last
  // load, and the result of the most recent accept awaiting scoring.
  bit         hist[$];
  int         fill_m;
  logic [7:0] pat_m;
  bit         pend_acc, pend_full;
  int         pend_score;
  int         score_m, hc_m;
  bit         valid_m, hit_m, full_m;

  function automatic int match_count();
    int cnt = 0;
    for (int i = 0; i < WL; i++) begin
      bit wb;
      wb = (i < hist.size()) ? hist[hist.size() - 1 - i] : 1'b0;
      if (wb == pat_m[i]) cnt++;
    end
    return cnt;
  endfunction

  task automatic model_edge(input bit r, input bit v, input bit b, input bit pl,
                            input logic [7:0] pv, input int th);
    if (r) begin
      hist.delete();
      fill_m = 0; pat_m = 8'h00; pend_acc = 0; pend_full = 0; pend_score = 0;
      score_m = 0; valid_m = 0; hit_m = 0; full_m = 0; hc_m = 0;
    end else begin
      valid_m = pend_acc && pend_full && !pl;
      if (pend_acc && !pl) score_m = pend_score;
      hit_m = valid_m && (pend_score >= th);
      if (pl) hc_m = 0;
      else if (hit_m && hc_m != 65535) hc_m++;
      if (pl) begin
        pat_m  = pv;
        fill_m = 0;
      end
      if (v) begin
        hist.push_back(b);
        if (hist.size() > WL) void'(hist.pop_front());
        if (fill_m < WL) fill_m++;
      end
      pend_acc   = v;
      pend_full  = (fill_m == WL);
      pend_score = match_count();
      full_m     = (fill_m == WL);
    end
  endtask

  // Drive one cycle, advance the model and compare every output.
  task automatic step(input bit r, input bit v, input bit b, input bit pl,
                      input logic [7:0] pv, input logic [3:0] th);
    rst = r; in_valid = v; in_bit = b; pat_load = pl; pat_value = pv; thresh = th;
    @(posedge clk);
    #1;
    model_edge(r, v, b, pl, pv, int'(th));
    check("model_full",  int'(window_full), int'(full_m));
    check("model_valid", int'(score_valid), int'(valid_m));
    check("model_hit",   int'(hit),         int'(hit_m));
    check("model_score", int'(score),       score_m);
`ifdef XCORR_HIT_COUNT_EN
    check("model_hitcnt", int'(hit_count), hc_m);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         r, v, b, pl;
    logic [7:0] pv;
    logic [3:0] th;
    bit         e_full, e_valid, e_hit, chk_score;
    int         e_score;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input bit b, input bit pl,
                     input logic [7:0] pv, input logic [3:0] th,
                     input bit ef, input bit ev, input bit eh,
                     input bit cs, input int es);
    vec_t t;
    t.r = r; t.v = v; t.b = b; t.pl = pl; t.pv = pv; t.th = th;
    t.e_full = ef; t.e_valid = ev; t.e_hit = eh; t.chk_score = cs; t.e_score = es;
    tbl.push_back(t);
  endtask

  // Feed the 8 bits of seq MSB first; only the last bit fills the window.
  task automatic add_seq(input logic [7:0] seq, input logic [3:0] th);
    for (int i = 7; i >= 0; i--) add(0, 1, seq[i], 0, 8'h00, th, (i == 0), 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] pv_r;

    // Reset state
    step(1, 0, 0, 0, 8'h00, 4'd0);
    step(1, 0, 0, 0, 8'h00, 4'd0);
    check("rst_full",  int'(window_full), 0);
    check("rst_valid", int'(score_valid), 0);
    check("rst_hit",   int'(hit), 0);
    check("rst_score", int'(score), 0);

    // 1: exact match
    add(0, 0, 0, 1, 8'hB4, 4'd8, 0, 0, 0, 0, 0);
    add_seq(8'hB4, 4'd8);
    add(0, 0, 0, 0, 8'h00, 4'd8, 1, 1, 1, 1, 8);
    // 2: one-bit error, thresh 7 then 8
    add(0, 0, 0, 1, 8'hB4, 4'd7, 0, 0, 0, 0, 0);
    add_seq(8'hB5, 4'd7);
    add(0, 0, 0, 0, 8'h00, 4'd7, 1, 1, 1, 1, 7);
    add(0, 0, 0, 1, 8'hB4, 4'd8, 0, 0, 0, 0, 0);
    add_seq(8'hB5, 4'd8);
    add(0, 0, 0, 0, 8'h00, 4'd8, 1, 1, 0, 1, 7);
    // 3: bubbles between every bit
    add(0, 0, 0, 1, 8'hB4, 4'd8, 0, 0, 0, 0, 0);
    s = 8'hB4;
    for (int i = 7; i >= 0; i--) begin
      add(0, 1, s[i], 0, 8'h00, 4'd8, (i == 0), 0, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, 4'd8, (i == 0), (i == 0), (i == 0), (i == 0), 8);
    end
    add(0, 0, 0, 0, 8'h00, 4'd8, 1, 0, 0, 1, 8);
    // 4: pattern load mid-stream together with a bit
    add(0, 0, 0, 1, 8'hB4, 4'd8, 0, 0, 0, 0, 0);
    s = 8'hB4;
    for (int i = 7; i >= 3; i--) add(0, 1, s[i], 0, 8'h00, 4'd8, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 8'h0F, 4'd8, 0, 0, 0, 0, 0);
    s = 8'h0F;
    for (int i = 6; i >= 0; i--) add(0, 1, s[i], 0, 8'h00, 4'd8, (i == 0), 0, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 4'd8, 1, 1, 1, 1, 8);
    // 5: reset mid-stream, then all-zero window vs cleared pattern
    add(0, 0, 0, 1, 8'hB4, 4'd8, 0, 0, 0, 0, 0);
    s = 8'hB4;
    for (int i = 7; i >= 2; i--) add(0, 1, s[i], 0, 8'h00, 4'd8, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 4'd8, 0, 0, 0, 1, 0);
    add_seq(8'h00, 4'd8);
    add(0, 0, 0, 0, 8'h00, 4'd8, 1, 1, 1, 1, 8);

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].v, tbl[k].b, tbl[k].pl, tbl[k].pv, tbl[k].th);
      check($sformatf("vec%0d_full", k),  int'(window_full), int'(tbl[k].e_full));
      check($sformatf("vec%0d_valid", k), int'(score_valid), int'(tbl[k].e_valid));
      check($sformatf("vec%0d_hit", k),   int'(hit),         int'(tbl[k].e_hit));
      if (tbl[k].chk_score) check($sformatf("vec%0d_score", k), int'(score), tbl[k].e_score);
    end

    // 6: threshold corners and hit counter
    pv_r = 8'($urandom);
    step(1, 0, 0, 0, 8'h00, 4'd0);
    step(0, 0, 0, 1, pv_r, 4'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 1'($urandom), 0, 8'h00, 4'd0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 1'($urandom), 0, 8'h00, 4'd0);
      check("th0_valid", int'(score_valid), 1);
      check("th0_hit",   int'(hit), 1);
    end
    step(0, 0, 0, 0, 8'h00, 4'd0);
    check("th0_last_hit", int'(hit), 1);
    step(0, 0, 0, 0, 8'h00, 4'd0);
`ifdef XCORR_HIT_COUNT_EN
    check("hitcnt_10", int'(hit_count), 10);
`endif
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1'($urandom), 0, 8'h00, 4'd9);
      check("th9_hit", int'(hit), 0);
    end
    step(0, 0, 0, 0, 8'h00, 4'd9);
    check("th9_valid", int'(score_valid), 1);
    check("th9_hit_idle", int'(hit), 0);
    step(0, 0, 0, 1, pv_r, 4'd0);
`ifdef XCORR_HIT_COUNT_EN
    check("hitcnt_clear", int'(hit_count), 0);
`endif

    // Random phase against the reference model
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 80) == 0, ($urandom % 4) != 0, 1'($urandom),
           ($urandom % 30) == 0, 8'($urandom), 4'($urandom_range(0, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
